// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - MCP3008-style SPI ADC responder fed from a parallel channel bus.
// Optional LSB-first trail after B0 when ADC_RESP_LSBFIRST_EN is defined.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NCH         = 8,
  parameter int RES_BITS    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    din,
  input  logic [NCH*RES_BITS-1:0] ch_data,
  output logic                    dout,
  output logic                    dout_en,
  output logic                    conv_valid,
  output logic [2:0]              conv_ch,
  output logic                    conv_sgl,
  output logic                    frame_err
);

  localparam int CW = $clog2(RES_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_NULL, S_DATA, S_TRAIL
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
  logic sclk_q, cs_q, din_q;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  // cs chain resets low so a select held through reset never looks like a fresh cs_fall
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      din_sync  <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      din_q     <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
      din_q     <= din_sync[SYNC_STAGES-1];
      sck_rise  <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
      sck_fall  <= ~sclk_sync[SYNC_STAGES-1] & sclk_q;
      cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_q;
      cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_q;
    end
  end

  logic [RES_BITS-1:0] chan [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = ch_data[k*RES_BITS +: RES_BITS];
  end

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [2:0]          cmd, cmd_nxt;
  logic                seen, seen_nxt;
  logic [RES_BITS-1:0] sh, sh_nxt;
  logic                dout_nxt, dout_en_nxt, conv_valid_nxt, frame_err_nxt, conv_sgl_nxt;
  logic [2:0]          conv_ch_nxt;
  logic [2:0]          sel;
  logic [RES_BITS:0]   diff;
  logic [RES_BITS-1:0] result;

  // cmd holds {SGL, D2, D1}; din_q supplies D0 on the cycle the result is latched
  always_comb begin
    sel  = {cmd[1:0], din_q};
    diff = {1'b0, chan[sel]} - {1'b0, chan[{cmd[1:0], ~din_q}]};
    if (cmd[2])
      result = chan[sel];
    else if (diff[RES_BITS])
      result = '0;
    else
      result = diff[RES_BITS-1:0];
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cmd_nxt        = cmd;
    seen_nxt       = seen;
    sh_nxt         = sh;
    dout_nxt       = dout;
    dout_en_nxt    = dout_en;
    conv_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    conv_ch_nxt    = conv_ch;
    conv_sgl_nxt   = conv_sgl;
    if (cs_rise) begin
      state_nxt     = S_IDLE;
      dout_nxt      = 1'b0;
      dout_en_nxt   = 1'b0;
      frame_err_nxt = (state == S_WAIT_START && seen) || state == S_CMD ||
                      state == S_NULL || state == S_DATA;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state_nxt = S_WAIT_START;
            seen_nxt  = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (sck_rise) begin
            seen_nxt = 1'b1;
            if (din_q) begin
              state_nxt = S_CMD;
              cnt_nxt   = '0;
            end
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            if (cnt == CW'(3)) begin
              sh_nxt         = result;
              conv_valid_nxt = 1'b1;
              conv_ch_nxt    = sel;
              conv_sgl_nxt   = cmd[2];
              state_nxt      = S_NULL;
            end else begin
              cmd_nxt = {cmd[1:0], din_q};
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        S_NULL: begin
          if (sck_fall) begin
            dout_en_nxt = 1'b1;
            dout_nxt    = 1'b0;
            state_nxt   = S_DATA;
            cnt_nxt     = '0;
          end
        end
        S_DATA: begin
          // rotate so the word is back in original order when TRAIL starts
          if (sck_fall) begin
            dout_nxt = sh[RES_BITS-1];
            sh_nxt   = {sh[RES_BITS-2:0], sh[RES_BITS-1]};
            if (cnt == CW'(RES_BITS - 1))
              state_nxt = S_TRAIL;
            else
              cnt_nxt = cnt + CW'(1);
          end
        end
        S_TRAIL: begin
          if (sck_fall) begin
`ifdef ADC_RESP_LSBFIRST_EN
            dout_nxt = sh[1];
            sh_nxt   = sh >> 1;
`else
            dout_nxt = 1'b0;
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cmd        <= '0;
      seen       <= 1'b0;
      sh         <= '0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      conv_valid <= 1'b0;
      conv_ch    <= '0;
      conv_sgl   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cmd        <= cmd_nxt;
      seen       <= seen_nxt;
      sh         <= sh_nxt;
      dout       <= dout_nxt;
      dout_en    <= dout_en_nxt;
      conv_valid <= conv_valid_nxt;
      conv_ch    <= conv_ch_nxt;
      conv_sgl   <= conv_sgl_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule
